// File: rtl/wvb_rd_ctrl.sv
// Waveform buffer readout: pops event headers, reads the inclusive (wrapping) address range
// from the waveform RAM and streams one header beat plus the waveform words via a skid FIFO.
module wvb_rd_ctrl #(
    parameter int P_ADR_WIDTH  = 12,
    parameter int P_DATA_WIDTH = 64,
    parameter int P_LTC_WIDTH  = 48,
    parameter int P_RD_LAT     = 2,
    parameter int P_SKID_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hdr_empty,
    input  logic [P_LTC_WIDTH-1:0]  hdr_evt_ltc,
    input  logic [P_ADR_WIDTH-1:0]  hdr_start_addr,
    input  logic [P_ADR_WIDTH-1:0]  hdr_stop_addr,
    output logic                    hdr_rdreq,
    output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
    output logic                    wvb_rd_en,
    input  logic [P_DATA_WIDTH-1:0] wvb_rd_data,
    output logic [P_DATA_WIDTH-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_sof,
    output logic                    dout_eof,
    output logic [P_ADR_WIDTH-1:0]  rd_ptr,
    output logic                    busy
);
    localparam int CNT_W = $clog2(P_SKID_DEPTH + 1);
    localparam int IDX_W = (P_SKID_DEPTH > 1) ? $clog2(P_SKID_DEPTH) : 1;
    localparam int LEN_W = P_ADR_WIDTH + 1;
    localparam logic [LEN_W-1:0]       LEN_ONE  = LEN_W'(1);
    localparam logic [P_ADR_WIDTH-1:0] ADR_ONE  = P_ADR_WIDTH'(1);
    localparam logic [IDX_W-1:0]       IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(P_SKID_DEPTH - 1);
    localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [P_LTC_WIDTH-1:0]  ltc_q, ltc_d;
    logic [P_ADR_WIDTH-1:0]  startAddr_q, startAddr_d;
    logic [P_ADR_WIDTH-1:0]  stopAddr_q, stopAddr_d;
    logic [P_ADR_WIDTH-1:0]  rdAddr_q, rdAddr_d;
    logic [P_ADR_WIDTH-1:0]  rdPtr_q, rdPtr_d;
    logic [LEN_W-1:0]        nWords_q, nWords_d;
    logic [LEN_W-1:0]        remain_q, remain_d;
    logic [P_RD_LAT-1:0]     pipeVld_q, pipeEof_q;

    logic [P_DATA_WIDTH+1:0] skidMem [P_SKID_DEPTH];
    logic [IDX_W-1:0]        wrIdx_q, rdIdx_q;
    logic [CNT_W-1:0]        count_q;

    logic                    credit, issue, issueEof, hdrPush, push, pop, popEof;
    logic [P_DATA_WIDTH-1:0] hdrBeat;
    logic [P_DATA_WIDTH+1:0] pushWord, headWord;
    int                      inflight;

    // A read may only start if its data is guaranteed a skid slot when it returns.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < P_RD_LAT; i++) begin
            inflight += int'(pipeVld_q[i]);
        end
        credit = (int'(count_q) + inflight) < P_SKID_DEPTH;
    end

    always_comb begin
        hdrBeat = '0;
        hdrBeat[P_LTC_WIDTH-1:0]      = ltc_q;
        hdrBeat[P_LTC_WIDTH +: LEN_W] = nWords_q;
    end

    always_comb begin
        state_d     = state_q;
        ltc_d       = ltc_q;
        startAddr_d = startAddr_q;
        stopAddr_d  = stopAddr_q;
        nWords_d    = nWords_q;
        rdAddr_d    = rdAddr_q;
        remain_d    = remain_q;
        rdPtr_d     = rdPtr_q;
        hdr_rdreq   = 1'b0;
        issue       = 1'b0;
        issueEof    = 1'b0;
        hdrPush     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!hdr_empty && rst_n) begin
                    hdr_rdreq   = 1'b1;
                    ltc_d       = hdr_evt_ltc;
                    startAddr_d = hdr_start_addr;
                    stopAddr_d  = hdr_stop_addr;
                    nWords_d    = {1'b0, hdr_stop_addr - hdr_start_addr} + LEN_ONE;
                    state_d     = S_HDR;
                end
            end
            S_HDR: begin
                if (credit) begin
                    hdrPush  = 1'b1;
                    rdAddr_d = startAddr_q;
                    remain_d = nWords_q;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (credit) begin
                    issue    = 1'b1;
                    issueEof = (remain_q == LEN_ONE);
                    rdAddr_d = rdAddr_q + ADR_ONE;
                    remain_d = remain_q - LEN_ONE;
                    if (remain_q == LEN_ONE) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (popEof) begin
                    rdPtr_d = stopAddr_q + ADR_ONE;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Header and RAM returns never coincide: a header is only pushed once the read pipe is empty.
    assign push       = hdrPush || pipeVld_q[P_RD_LAT-1];
    assign pushWord   = hdrPush ? {1'b0, 1'b1, hdrBeat}
                                : {pipeEof_q[P_RD_LAT-1], 1'b0, wvb_rd_data};
    assign headWord   = skidMem[rdIdx_q];
    assign dout_valid = (count_q != '0);
    assign pop        = dout_valid && dout_ready;
    assign dout       = dout_valid ? headWord[P_DATA_WIDTH-1:0] : '0;
    assign dout_sof   = dout_valid && headWord[P_DATA_WIDTH];
    assign dout_eof   = dout_valid && headWord[P_DATA_WIDTH+1];
    assign popEof     = pop && dout_eof;

    assign wvb_rd_en   = issue;
    assign wvb_rd_addr = rdAddr_q;
    assign rd_ptr      = rdPtr_q;
    assign busy        = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ltc_q       <= '0;
            startAddr_q <= '0;
            stopAddr_q  <= '0;
            nWords_q    <= '0;
            rdAddr_q    <= '0;
            remain_q    <= '0;
            rdPtr_q     <= '0;
            pipeVld_q   <= '0;
            pipeEof_q   <= '0;
            wrIdx_q     <= '0;
            rdIdx_q     <= '0;
            count_q     <= '0;
        end else begin
            state_q      <= state_d;
            ltc_q        <= ltc_d;
            startAddr_q  <= startAddr_d;
            stopAddr_q   <= stopAddr_d;
            nWords_q     <= nWords_d;
            rdAddr_q     <= rdAddr_d;
            remain_q     <= remain_d;
            rdPtr_q      <= rdPtr_d;
            pipeVld_q[0] <= issue;
            pipeEof_q[0] <= issueEof;
            for (int i = 1; i < P_RD_LAT; i++) begin
                pipeVld_q[i] <= pipeVld_q[i-1];
                pipeEof_q[i] <= pipeEof_q[i-1];
            end
            if (push) begin
                wrIdx_q <= (wrIdx_q == IDX_LAST) ? '0 : wrIdx_q + IDX_ONE;
            end
            if (pop) begin
                rdIdx_q <= (rdIdx_q == IDX_LAST) ? '0 : rdIdx_q + IDX_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            skidMem[wrIdx_q] <= pushWord;
        end
    end

endmodule

// File: tb/tb_wvb_rd_ctrl.sv
// Directed bench for wvb_rd_ctrl: models the header FIFO and a 2-cycle waveform RAM and
// checks every streamed packet against hand-derived headers, addresses and rd_ptr values.
module tb_wvb_rd_ctrl;
    localparam int AW  = 12;
    localparam int DW  = 64;
    localparam int LW  = 48;
    localparam int LAT = 2;
    localparam int SD  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hdr_empty;
    logic [LW-1:0] hdr_evt_ltc;
    logic [AW-1:0] hdr_start_addr, hdr_stop_addr;
    logic          hdr_rdreq;
    logic [AW-1:0] wvb_rd_addr;
    logic          wvb_rd_en;
    logic [DW-1:0] wvb_rd_data;
    logic [DW-1:0] dout;
    logic          dout_valid, dout_ready, dout_sof, dout_eof;
    logic [AW-1:0] rd_ptr;
    logic          busy;

    typedef struct {
        logic [DW-1:0] data;
        logic          sof;
        logic          eof;
        logic [AW-1:0] rdp;
        int            cyc;
    } beat_t;

    beat_t capQ[$];
    int total = 0;
    int bad = 0;
    int cycleNo = 0;
    int eofCount = 0;
    int rdreqCount = 0;
    int issued = 0;
    int dataXfers = 0;
    int maxOut = 0;
    int stallViol = 0;
    int readyMode = 0;

    wvb_rd_ctrl #(
        .P_ADR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_LTC_WIDTH(LW),
        .P_RD_LAT(LAT), .P_SKID_DEPTH(SD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .hdr_empty(hdr_empty), .hdr_evt_ltc(hdr_evt_ltc),
        .hdr_start_addr(hdr_start_addr), .hdr_stop_addr(hdr_stop_addr),
        .hdr_rdreq(hdr_rdreq),
        .wvb_rd_addr(wvb_rd_addr), .wvb_rd_en(wvb_rd_en), .wvb_rd_data(wvb_rd_data),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_sof(dout_sof), .dout_eof(dout_eof),
        .rd_ptr(rd_ptr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Show-ahead header FIFO model; popped on the edge that samples hdr_rdreq high.
    logic [LW-1:0] hLtc [16];
    logic [AW-1:0] hStart [16];
    logic [AW-1:0] hStop [16];
    logic [3:0]    hdrHead = 4'd0;
    logic [3:0]    hdrTail = 4'd0;

    assign hdr_empty      = (hdrHead == hdrTail);
    assign hdr_evt_ltc    = hLtc[hdrHead];
    assign hdr_start_addr = hStart[hdrHead];
    assign hdr_stop_addr  = hStop[hdrHead];

    always @(posedge clk) begin
        cycleNo <= cycleNo + 1;
        if (hdr_rdreq && !hdr_empty) begin
            hdrHead    <= hdrHead + 4'd1;
            rdreqCount <= rdreqCount + 1;
        end
    end

    // Waveform RAM model: content is a fixed function of the address, LAT cycles of latency.
    function automatic logic [DW-1:0] ramWord(input logic [AW-1:0] a);
        return {16'hDA7A, 4'h0, a, 16'h5EED, 4'h0, a};
    endfunction

    logic [DW-1:0] ramP [LAT];
    always @(posedge clk) begin
        ramP[0] <= wvb_rd_en ? ramWord(wvb_rd_addr) : 64'hDEAD_DEAD_DEAD_DEAD;
        for (int i = 1; i < LAT; i++) ramP[i] <= ramP[i-1];
    end
    assign wvb_rd_data = ramP[LAT-1];

    // Stream monitor: captures transfers, tracks outstanding reads and stall stability.
    logic          prevStall = 1'b0;
    logic [DW+1:0] prevOut = '0;
    beat_t         mb;
    always @(negedge clk) begin
        if (wvb_rd_en) issued++;
        if (prevStall && ({dout_valid, dout_sof, dout_eof, dout} !== {1'b1, prevOut})) stallViol++;
        prevStall = dout_valid && !dout_ready && rst_n;
        prevOut   = {dout_sof, dout_eof, dout};
        if (dout_valid && dout_ready) begin
            mb.data = dout;
            mb.sof  = dout_sof;
            mb.eof  = dout_eof;
            mb.rdp  = rd_ptr;
            mb.cyc  = cycleNo;
            capQ.push_back(mb);
            if (!dout_sof) dataXfers++;
            if (dout_eof) eofCount++;
        end
        if (issued - dataXfers > maxOut) maxOut = issued - dataXfers;
    end

    // Ready pattern generator: mode 1 gives one cycle high then two low.
    initial begin
        int ph = 0;
        dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (readyMode == 1) begin
                dout_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end else begin
                dout_ready = 1'b1;
                ph = 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [LW-1:0] ltc, input logic [AW-1:0] s, input logic [AW-1:0] e);
        hLtc[hdrTail]   = ltc;
        hStart[hdrTail] = s;
        hStop[hdrTail]  = e;
        hdrTail = hdrTail + 4'd1;
    endtask

    task automatic waitEofs(input int target, input int budget);
        int n = 0;
        while (eofCount < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput("eofWait", eofCount, target);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic checkEvent(input string name, input int base, input logic [LW-1:0] ltc,
                              input logic [AW-1:0] s, input int n, input logic [AW-1:0] prevPtr);
        logic [DW-1:0] h;
        logic [AW-1:0] a;
        int b0;
        h = '0;
        h[LW-1:0]     = ltc;
        h[LW +: AW+1] = (AW+1)'(n);
        checkOutput({name, ".present"}, capQ.size() >= base + n + 1, 1);
        if (capQ.size() > base)
            checkOutput({name, ".hdr"},
                        {capQ[base].sof, capQ[base].eof, capQ[base].rdp, capQ[base].data},
                        {1'b1, 1'b0, prevPtr, h});
        a = s;
        for (int i = 1; i <= n && base + i < capQ.size(); i++) begin
            b0 = bad;
            checkOutput($sformatf("%s.beat%0d", name, i),
                        {capQ[base+i].sof, capQ[base+i].eof, capQ[base+i].rdp, capQ[base+i].data},
                        {1'b0, (i == n), prevPtr, ramWord(a)});
            if (bad != b0) break;
            a = a + AW'(1);
        end
    endtask

    task automatic runSingle(input string name, input logic [LW-1:0] ltc, input logic [AW-1:0] s,
                             input logic [AW-1:0] e, input int n, input logic [AW-1:0] prevPtr,
                             input logic [AW-1:0] nextPtr, input int budget);
        int base, rq, tgt;
        base = capQ.size();
        rq   = rdreqCount;
        tgt  = eofCount + 1;
        applyStimulus(ltc, s, e);
        waitEofs(tgt, budget);
        checkOutput({name, ".count"}, capQ.size() - base, n + 1);
        checkEvent(name, base, ltc, s, n, prevPtr);
        checkOutput({name, ".rdPtr"}, rd_ptr, nextPtr);
        checkOutput({name, ".rdreq"}, rdreqCount - rq, 1);
        checkOutput({name, ".idle"}, busy, 1'b0);
    endtask

    initial begin
        int base, rq, tgt, n, eofBefore;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetOutputs",
                    {hdr_rdreq, wvb_rd_en, wvb_rd_addr, dout, dout_valid, dout_sof, dout_eof, rd_ptr, busy}, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        runSingle("single", 48'h1234_5678_9ABC, 12'h010, 12'h013, 4, 12'h000, 12'h014, 200);
        runSingle("wrap",   48'hA1A1_0000_0002, 12'hFFE, 12'h001, 4, 12'h014, 12'h002, 200);

        readyMode = 1;
        runSingle("bp",     48'hB0B0_0000_0040, 12'h300, 12'h33F, 64, 12'h002, 12'h340, 600);
        checkOutput("bp.stallStable", stallViol, 0);
        checkOutput($sformatf("bp.maxOutstanding(%0d)", maxOut), maxOut <= SD, 1);
        readyMode = 0;
        repeat (3) @(posedge clk);
        #1;

        runSingle("oneWord", 48'h0000_0000_0100, 12'h100, 12'h100, 1, 12'h340, 12'h101, 200);
        runSingle("full",    48'hF0F0_0000_1000, 12'h200, 12'h1FF, 4096, 12'h101, 12'h200, 6000);

        base = capQ.size();
        rq   = rdreqCount;
        tgt  = eofCount + 3;
        applyStimulus(48'h0000_0000_0E01, 12'h400, 12'h407);
        applyStimulus(48'h0000_0000_0E02, 12'h800, 12'h802);
        applyStimulus(48'h0000_0000_0E03, 12'hA00, 12'hA00);
        waitEofs(tgt, 400);
        checkOutput("b2b.count", capQ.size() - base, 15);
        checkEvent("b2b.e1", base,      48'h0000_0000_0E01, 12'h400, 8, 12'h200);
        checkEvent("b2b.e2", base + 9,  48'h0000_0000_0E02, 12'h800, 3, 12'h408);
        checkEvent("b2b.e3", base + 13, 48'h0000_0000_0E03, 12'hA00, 1, 12'h803);
        if (capQ.size() >= base + 15) begin
            checkOutput("b2b.gap12", (capQ[base+9].cyc - capQ[base+8].cyc - 1) <= 2, 1);
            checkOutput("b2b.gap23", (capQ[base+13].cyc - capQ[base+12].cyc - 1) <= 2, 1);
        end
        checkOutput("b2b.rdPtr", rd_ptr, 12'hA01);
        checkOutput("b2b.rdreq", rdreqCount - rq, 3);

        base = capQ.size();
        applyStimulus(48'h0000_0000_5100, 12'h500, 12'h563);
        applyStimulus(48'h0000_0000_7006, 12'h700, 12'h705);
        n = 0;
        while (capQ.size() - base < 20 && n < 500) begin
            @(posedge clk);
            n++;
        end
        checkOutput("rst.progress", capQ.size() - base >= 20, 1);
        #1;
        eofBefore = eofCount;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst.outputs",
                    {hdr_rdreq, wvb_rd_en, wvb_rd_addr, dout, dout_valid, dout_sof, dout_eof, rd_ptr, busy}, '0);
        @(posedge clk);
        #1;
        checkOutput("rst.noEof", eofCount, eofBefore);
        base = capQ.size();
        rq   = rdreqCount;
        tgt  = eofCount + 1;
        rst_n = 1'b1;
        waitEofs(tgt, 200);
        checkOutput("rst.count", capQ.size() - base, 7);
        checkEvent("rst.next", base, 48'h0000_0000_7006, 12'h700, 6, 12'h000);
        checkOutput("rst.rdPtr", rd_ptr, 12'h706);
        checkOutput("rst.rdreq", rdreqCount - rq, 1);

        $display("[TB] directed sequence complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
